// File: rtl/ls_queue.sv
// In-order load/store queue between dispatch and the data-cache/IO arbiter.
// Holds operands until they are ready, issues one memory access at a time and broadcasts load results.
module ls_queue #(
  parameter int DEPTH = 16,
  parameter int ROB_W = 5,
  parameter int DAT_W = 32,
  parameter int CDB_N = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [3:0]             in_op,
  input  logic [ROB_W-1:0]       in_qj,
  input  logic [ROB_W-1:0]       in_qk,
  input  logic [ROB_W-1:0]       in_qd,
  input  logic [DAT_W-1:0]       in_vj,
  input  logic [DAT_W-1:0]       in_vk,
  input  logic [DAT_W-1:0]       in_imm,
  output logic                   full,
  input  logic [CDB_N-1:0]       cdb_valid,
  input  logic [CDB_N*ROB_W-1:0] cdb_q,
  input  logic [CDB_N*DAT_W-1:0] cdb_v,
  input  logic                   rob_commit,
  input  logic [ROB_W-1:0]       rob_head_q,
  input  logic                   flush,
  input  logic                   io_busy,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [2:0]             mem_len,
  output logic [DAT_W-1:0]       mem_addr,
  output logic [DAT_W-1:0]       mem_wdata,
  input  logic                   mem_ack,
  input  logic [DAT_W-1:0]       mem_rdata,
  output logic                   ld_valid,
  output logic [ROB_W-1:0]       ld_q,
  output logic [DAT_W-1:0]       ld_v,
  output logic [$clog2(DEPTH):0] cmt_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DRAIN = 2'd2} state_t;

  typedef struct packed {
    logic [ROB_W-1:0] q;
    logic [DAT_W-1:0] v;
  } opnd_t;

  state_t           state, state_next;
  logic [3:0]       op  [DEPTH];
  logic [ROB_W-1:0] qj  [DEPTH];
  logic [ROB_W-1:0] qk  [DEPTH];
  logic [ROB_W-1:0] qd  [DEPTH];
  logic [DAT_W-1:0] vj  [DEPTH];
  logic [DAT_W-1:0] vk  [DEPTH];
  logic [DAT_W-1:0] imm [DEPTH];
  logic [AW-1:0]    head, tail;
  logic [CW-1:0]    count, keep;
  logic [DEPTH-1:0] discard;

  logic [3:0]       head_op;
  logic [DAT_W-1:0] head_addr, lack_val;
  logic             head_store, head_ready, head_io;
  logic             push, pop, load_ack, store_ack, issue;

  function automatic logic [DAT_W-1:0] extend(input logic [DAT_W-1:0] d, input logic [3:0] o);
    logic [DAT_W-1:0] r;
    case (o[1:0])
      2'd0:    r = o[2] ? {{(DAT_W-8){1'b0}}, d[7:0]}   : {{(DAT_W-8){d[7]}}, d[7:0]};
      2'd1:    r = o[2] ? {{(DAT_W-16){1'b0}}, d[15:0]} : {{(DAT_W-16){d[15]}}, d[15:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic logic [2:0] size_len(input logic [1:0] sz);
    logic [2:0] r;
    case (sz)
      2'd0:    r = 3'd1;
      2'd1:    r = 3'd2;
      default: r = 3'd4;
    endcase
    return r;
  endfunction

  // A waiting tag picks up a head-load result or a CDB value; the highest matching channel wins.
  function automatic opnd_t resolve(input logic [ROB_W-1:0] q, input logic [DAT_W-1:0] v);
    opnd_t r;
    r.q = q;
    r.v = v;
    if (q != {ROB_W{1'b0}}) begin
      if (load_ack && q == qd[head]) begin
        r.q = {ROB_W{1'b0}};
        r.v = lack_val;
      end
      for (int c = 0; c < CDB_N; c++) begin
        if (cdb_valid[c] && cdb_q[c*ROB_W +: ROB_W] == q) begin
          r.q = {ROB_W{1'b0}};
          r.v = cdb_v[c*DAT_W +: DAT_W];
        end
      end
    end
    return r;
  endfunction

  assign head_op    = op[head];
  assign head_addr  = vj[head] + imm[head];
  assign head_store = head_op[3];
  assign head_ready = (qj[head] == {ROB_W{1'b0}}) && (qk[head] == {ROB_W{1'b0}});
  assign head_io    = (head_addr[17:16] == 2'b11);
  assign lack_val   = extend(mem_rdata, head_op);
  assign push       = in_valid && !flush;
  assign pop        = mem_ack && (state != IDLE);
  assign load_ack   = mem_ack && (state == WAIT) && !head_store;
  assign store_ack  = mem_ack && (state == WAIT) && head_store;
  assign full       = (count >= CW'(DEPTH - 2));

  // Issue decision, flush keep-count and next FSM state.
  always_comb begin
    issue = 1'b0;
    if (state == IDLE && count != {CW{1'b0}} && head_ready && !io_busy && !flush) begin
      if (head_store) begin
        issue = (cmt_cnt != {CW{1'b0}});
      end else begin
        issue = !head_io || (rob_head_q == qd[head]);
      end
    end else begin
      issue = 1'b0;
    end

    // The ghost load in DRAIN still occupies the head slot until its ack pops it.
    keep = cmt_cnt + {{AW{1'b0}}, rob_commit};
    if (state == WAIT && !head_store) begin
      keep = {{AW{1'b0}}, 1'b1};
    end else if (state == DRAIN) begin
      keep = keep + {{AW{1'b0}}, 1'b1};
    end else begin
      keep = keep;
    end

    for (int i = 0; i < DEPTH; i++) begin
      discard[i] = ({1'b0, AW'(i) - head} >= keep) && ({1'b0, AW'(i) - head} < count);
    end

    state_next = state;
    case (state)
      IDLE:    state_next = issue ? WAIT : IDLE;
      WAIT: begin
        if (mem_ack) begin
          state_next = IDLE;
        end else if (flush && !head_store) begin
          state_next = DRAIN;
        end else begin
          state_next = WAIT;
        end
      end
      DRAIN:   state_next = mem_ack ? IDLE : DRAIN;
      default: state_next = IDLE;
    endcase
  end

  // Entry storage: capture on enqueue, wake up waiting operands, clear discarded ops on flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        op[i]  <= 4'd0;
        qj[i]  <= {ROB_W{1'b0}};
        qk[i]  <= {ROB_W{1'b0}};
        qd[i]  <= {ROB_W{1'b0}};
        vj[i]  <= {DAT_W{1'b0}};
        vk[i]  <= {DAT_W{1'b0}};
        imm[i] <= {DAT_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (push && AW'(i) == tail) begin
          op[i]            <= in_op;
          {qj[i], vj[i]}   <= resolve(in_qj, in_vj);
          {qk[i], vk[i]}   <= resolve(in_qk, in_vk);
          qd[i]            <= in_qd;
          imm[i]           <= in_imm;
        end else begin
          {qj[i], vj[i]}   <= resolve(qj[i], vj[i]);
          {qk[i], vk[i]}   <= resolve(qk[i], vk[i]);
          if (flush && discard[i]) begin
            op[i] <= 4'd0;
          end
        end
      end
    end
  end

  // Pointers, occupancy and committed-store count.
  always_ff @(posedge clk) begin
    if (rst) begin
      head    <= {AW{1'b0}};
      tail    <= {AW{1'b0}};
      count   <= {CW{1'b0}};
      cmt_cnt <= {CW{1'b0}};
    end else begin
      head    <= head + {{(AW-1){1'b0}}, pop};
      cmt_cnt <= cmt_cnt + {{AW{1'b0}}, rob_commit} - {{AW{1'b0}}, store_ack};
      if (flush) begin
        tail  <= head + keep[AW-1:0];
        count <= keep - {{AW{1'b0}}, pop};
      end else begin
        tail  <= tail + {{(AW-1){1'b0}}, push};
        count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      end
    end
  end

  // FSM state plus registered memory request and load result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_len   <= 3'd0;
      mem_addr  <= {DAT_W{1'b0}};
      mem_wdata <= {DAT_W{1'b0}};
      ld_valid  <= 1'b0;
      ld_q      <= {ROB_W{1'b0}};
      ld_v      <= {DAT_W{1'b0}};
    end else begin
      state <= state_next;
      if (issue) begin
        mem_req   <= 1'b1;
        mem_we    <= head_store;
        mem_len   <= size_len(head_op[1:0]);
        mem_addr  <= head_addr;
        mem_wdata <= vk[head];
      end else if (pop) begin
        mem_req <= 1'b0;
      end
      ld_valid <= load_ack && !flush;
      if (load_ack && !flush) begin
        ld_q <= qd[head];
        ld_v <= lack_val;
      end
    end
  end

endmodule

// File: tb/tb_ls_queue.sv
// Scoreboard bench for ls_queue: expected memory requests and load results are queued
// as stimulus is driven and compared when the DUT issues or broadcasts.
module tb_ls_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [3:0]  in_op;
  logic [4:0]  in_qj, in_qk, in_qd;
  logic [31:0] in_vj, in_vk, in_imm;
  logic        full;
  logic [1:0]  cdb_valid;
  logic [9:0]  cdb_q;
  logic [63:0] cdb_v;
  logic        rob_commit;
  logic [4:0]  rob_head_q;
  logic        flush, io_busy;
  logic        mem_req, mem_we;
  logic [2:0]  mem_len;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        ld_valid;
  logic [4:0]  ld_q;
  logic [31:0] ld_v;
  logic [4:0]  cmt_cnt;

  typedef struct {
    logic        we;
    logic [2:0]  len;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  qd;
  } req_t;

  typedef struct {
    logic [4:0]  q;
    logic [31:0] v;
  } ld_t;

  req_t exp_req[$];
  ld_t  exp_ld[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  ls_queue dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_op(in_op),
    .in_qj(in_qj), .in_qk(in_qk), .in_qd(in_qd),
    .in_vj(in_vj), .in_vk(in_vk), .in_imm(in_imm), .full(full),
    .cdb_valid(cdb_valid), .cdb_q(cdb_q), .cdb_v(cdb_v),
    .rob_commit(rob_commit), .rob_head_q(rob_head_q), .flush(flush), .io_busy(io_busy),
    .mem_req(mem_req), .mem_we(mem_we), .mem_len(mem_len), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .ld_valid(ld_valid), .ld_q(ld_q), .ld_v(ld_v), .cmt_cnt(cmt_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Enqueue one entry; when issue is set, the request it should produce joins the scoreboard.
  task automatic enq(input logic [3:0] op, input logic [4:0] qj, input logic [4:0] qk,
                     input logic [4:0] qd, input logic [31:0] vj, input logic [31:0] vk,
                     input logic [31:0] imm, input logic issue, input logic [31:0] wdata);
    req_t r;
    in_valid = 1'b1; in_op = op; in_qj = qj; in_qk = qk; in_qd = qd;
    in_vj = vj; in_vk = vk; in_imm = imm;
    if (issue) begin
      r.we    = op[3];
      r.len   = (op[1:0] == 2'd0) ? 3'd1 : (op[1:0] == 2'd1) ? 3'd2 : 3'd4;
      r.addr  = vj + imm;
      r.wdata = wdata;
      r.qd    = qd;
      exp_req.push_back(r);
    end
    tick();
    in_valid = 1'b0;
  endtask

  // Wait for the next request, check it against the scoreboard and acknowledge it.
  task automatic serve(input logic [31:0] rdata, input logic expect_ld, input logic [31:0] ld_exp);
    int   n;
    req_t r;
    ld_t  l;
    logic was_load;
    n = 0;
    while (mem_req !== 1'b1 && n < 64) begin
      tick();
      n++;
    end
    check("req_seen", {31'd0, mem_req}, 32'd1);
    if (mem_req === 1'b1) begin
      check("req_in_scoreboard", {31'd0, exp_req.size() != 0}, 32'd1);
      was_load = !mem_we;
      if (exp_req.size() != 0) begin
        r = exp_req.pop_front();
        check("req_we", {31'd0, mem_we}, {31'd0, r.we});
        check("req_len", {29'd0, mem_len}, {29'd0, r.len});
        check("req_addr", mem_addr, r.addr);
        if (r.we) check("req_wdata", mem_wdata, r.wdata);
        if (!r.we && expect_ld) begin
          l.q = r.qd;
          l.v = ld_exp;
          exp_ld.push_back(l);
        end
      end
      mem_rdata = rdata;
      mem_ack   = 1'b1;
      tick();
      mem_ack   = 1'b0;
      check("req_drop", {31'd0, mem_req}, 32'd0);
      if (was_load) check("ld_pulse", {31'd0, ld_valid}, {31'd0, expect_ld});
    end
  endtask

  // Load-result monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst && ld_valid === 1'b1) begin
      check("ld_expected", {31'd0, exp_ld.size() != 0}, 32'd1);
      if (exp_ld.size() != 0) begin
        ld_t e;
        e = exp_ld.pop_front();
        check("ld_q", {27'd0, ld_q}, {27'd0, e.q});
        check("ld_v", ld_v, e.v);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        seen;
    logic [31:0] sub_exp [4];
    int          n;

    rst = 1'b1; in_valid = 1'b0; in_op = 4'd0; in_qj = 5'd0; in_qk = 5'd0; in_qd = 5'd0;
    in_vj = 32'd0; in_vk = 32'd0; in_imm = 32'd0; cdb_valid = 2'd0; cdb_q = 10'd0;
    cdb_v = 64'd0; rob_commit = 1'b0; rob_head_q = 5'd0; flush = 1'b0; io_busy = 1'b0;
    mem_ack = 1'b0; mem_rdata = 32'd0;
    repeat (3) tick();
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_ld_valid", {31'd0, ld_valid}, 32'd0);
    check("rst_cmt_cnt", {27'd0, cmt_cnt}, 32'd0);
    check("rst_mem_len", {29'd0, mem_len}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_full", {31'd0, full}, 32'd0);
    rst = 1'b0;
    tick();

    // LW timing: request two cycles after enqueue, result one cycle after ack
    enq(4'b0010, 5'd0, 5'd0, 5'd1, 32'h100, 32'd0, 32'd4, 1'b1, 32'd0);
    check("lw_no_req_t1", {31'd0, mem_req}, 32'd0);
    tick();
    check("lw_req_t2", {31'd0, mem_req}, 32'd1);
    serve(32'hDEADBEEF, 1'b1, 32'hDEADBEEF);

    // sub-word loads with sign/zero extension
    sub_exp[0] = 32'hFFFFFFF0; sub_exp[1] = 32'h000000F0;
    sub_exp[2] = 32'hFFFF80F0; sub_exp[3] = 32'h000080F0;
    enq(4'b0000, 5'd0, 5'd0, 5'd2, 32'h200, 32'd0, 32'd0, 1'b1, 32'd0);
    enq(4'b0100, 5'd0, 5'd0, 5'd3, 32'h200, 32'd0, 32'd1, 1'b1, 32'd0);
    enq(4'b0001, 5'd0, 5'd0, 5'd4, 32'h200, 32'd0, 32'd2, 1'b1, 32'd0);
    enq(4'b0101, 5'd0, 5'd0, 5'd5, 32'h200, 32'd0, 32'd4, 1'b1, 32'd0);
    for (int i = 0; i < 4; i++) serve(32'h000080F0, 1'b1, sub_exp[i]);

    // SW waits on qk=3 via CDB channel 1, then waits for commit
    enq(4'b1010, 5'd0, 5'd3, 5'd9, 32'h300, 32'd0, 32'd0, 1'b1, 32'h55);
    cdb_valid = 2'b11; cdb_q = {5'd3, 5'd4}; cdb_v = {32'h55, 32'h99};
    tick();
    cdb_valid = 2'b00;
    seen = 1'b0;
    repeat (5) begin
      if (mem_req) seen = 1'b1;
      tick();
    end
    check("sw_held_no_commit", {31'd0, seen}, 32'd0);
    check("sw_cmt_zero", {27'd0, cmt_cnt}, 32'd0);
    rob_commit = 1'b1;
    tick();
    rob_commit = 1'b0;
    check("sw_cmt_one", {27'd0, cmt_cnt}, 32'd1);
    serve(32'd0, 1'b0, 32'd0);
    check("sw_cmt_after_ack", {27'd0, cmt_cnt}, 32'd0);

    // capture forwarding at enqueue; both channels match, channel 1 wins
    cdb_valid = 2'b11; cdb_q = {5'd6, 5'd6}; cdb_v = {32'h22, 32'h11};
    enq(4'b1010, 5'd0, 5'd6, 5'd10, 32'h340, 32'd0, 32'd0, 1'b1, 32'h22);
    cdb_valid = 2'b00;
    rob_commit = 1'b1;
    tick();
    rob_commit = 1'b0;
    serve(32'd0, 1'b0, 32'd0);

    // IO load waits for ROB head
    rob_head_q = 5'd5;
    enq(4'b0010, 5'd0, 5'd0, 5'd7, 32'h30000, 32'd0, 32'd0, 1'b1, 32'd0);
    seen = 1'b0;
    repeat (6) begin
      if (mem_req) seen = 1'b1;
      tick();
    end
    check("io_held", {31'd0, seen}, 32'd0);
    rob_head_q = 5'd7;
    serve(32'h1234, 1'b1, 32'h1234);
    rob_head_q = 5'd0;

    // flush during first store's WAIT keeps the two committed stores only
    enq(4'b1010, 5'd0, 5'd0, 5'd10, 32'h400, 32'hA1, 32'd0, 1'b1, 32'hA1);
    enq(4'b1010, 5'd0, 5'd0, 5'd11, 32'h404, 32'hA2, 32'd0, 1'b1, 32'hA2);
    enq(4'b0010, 5'd0, 5'd0, 5'd12, 32'h408, 32'd0, 32'd0, 1'b0, 32'd0);
    enq(4'b1010, 5'd0, 5'd0, 5'd13, 32'h40C, 32'hA4, 32'd0, 1'b0, 32'd0);
    rob_commit = 1'b1;
    tick();
    tick();
    rob_commit = 1'b0;
    check("fl_store_wait", {31'd0, mem_req}, 32'd1);
    check("fl_cmt_two", {27'd0, cmt_cnt}, 32'd2);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_req_held", {31'd0, mem_req}, 32'd1);
    serve(32'd0, 1'b0, 32'd0);
    serve(32'd0, 1'b0, 32'd0);
    seen = 1'b0;
    repeat (10) begin
      if (mem_req) seen = 1'b1;
      tick();
    end
    check("fl_lw_dropped", {31'd0, seen}, 32'd0);
    check("fl_cmt_zero", {27'd0, cmt_cnt}, 32'd0);

    // flush during a load in WAIT: DRAIN, ghost ack gives no result
    enq(4'b0010, 5'd0, 5'd0, 5'd14, 32'h500, 32'd0, 32'd0, 1'b1, 32'd0);
    n = 0;
    while (!mem_req && n < 20) begin
      tick();
      n++;
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("drain_req_held", {31'd0, mem_req}, 32'd1);
    enq(4'b0010, 5'd0, 5'd0, 5'd15, 32'h600, 32'd0, 32'd0, 1'b1, 32'd0);
    serve(32'hAAAA5555, 1'b0, 32'd0);
    serve(32'hBBBBCCCC, 1'b1, 32'hBBBBCCCC);

    // fill to DEPTH-2 with issue blocked
    io_busy = 1'b1;
    for (int i = 0; i < 14; i++) begin
      enq(4'b0010, 5'd0, 5'd0, 5'(i + 1), 32'h1000 + 32'(i * 4), 32'd0, 32'd0, 1'b1, 32'd0);
      if (i == 12) check("full_at_13", {31'd0, full}, 32'd0);
    end
    check("full_at_14", {31'd0, full}, 32'd1);
    io_busy = 1'b0;
    for (int i = 0; i < 14; i++) begin
      rd = $urandom;
      serve(rd, 1'b1, rd);
    end

    // 3*DEPTH enqueue/ack pairs across pointer wrap
    for (int i = 0; i < 48; i++) begin
      enq(4'b0010, 5'd0, 5'd0, 5'((i % 31) + 1), 32'h2000 + 32'(i * 4), 32'd0, 32'd0, 1'b1, 32'd0);
      rd = $urandom;
      serve(rd, 1'b1, rd);
    end

    // reset mid-transaction
    enq(4'b0010, 5'd0, 5'd0, 5'd20, 32'h700, 32'd0, 32'd0, 1'b0, 32'd0);
    n = 0;
    while (!mem_req && n < 20) begin
      tick();
      n++;
    end
    check("mid_req_up", {31'd0, mem_req}, 32'd1);
    rst = 1'b1;
    tick();
    check("mid_rst_req", {31'd0, mem_req}, 32'd0);
    check("mid_rst_cmt", {27'd0, cmt_cnt}, 32'd0);
    rst = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      if (mem_req) seen = 1'b1;
      tick();
    end
    check("mid_rst_empty", {31'd0, seen}, 32'd0);

    tick();
    tick();
    check("req_scoreboard_empty", exp_req.size(), 32'd0);
    check("ld_scoreboard_empty", exp_ld.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
